commutator_in: RTL and testbench

//  Input commutator for the radix-4 MDC FFT: serial-to-parallel converter and the reverse of the output skew stage.
//  - Accepts one complex sample per enabled clock.
//  - Buffers the first three quarters of each N-point frame.
//  - Emits aligned quadruples x[m], x[m+N/4], x[m+N/2], x[m+3N/4] on four lanes, directly feeding the first butterfly stage.

---
 rtl/commutator_in_pkg.sv | 21 ++
 rtl/commutator_in_quarter_buffer.sv | 27 ++
 rtl/commutator_in.sv | 125 ++++++++++++
 tb/tb_commutator_in.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/commutator_in_pkg.sv
// Shared radix-4 MDC FFT definitions: default word/frame sizes, lane count, clog2.
package commutator_in_pkg;

   localparam int unsigned WL_DEF = 16;
   localparam int unsigned N_DEF  = 16;
   localparam int unsigned LANES  = 4;

   // Ceiling log2; returns 0 for v <= 1
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned t;
      r = 0;
      t = 1;
      while (t < v) begin
         t = t << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/commutator_in_quarter_buffer.sv
// One quarter-frame sample store: synchronous write, asynchronous read.
module commutator_in_quarter_buffer #(
   parameter int unsigned WL = 16,
   parameter int unsigned AW = 2
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [2*WL-1:0] wdata,
   input  logic [AW-1:0]   raddr,
   output logic [2*WL-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [2*WL-1:0] mem_q [DEPTH];

   // Sample write; contents need no reset since every location is written before it is read
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/commutator_in.sv
// Input commutator for the radix-4 MDC FFT: buffers quarters 0..2 of each frame and
// emits aligned quadruples x[m], x[m+N/4], x[m+N/2], x[m+3N/4] during quarter 3.
// Optional macro COMMUTATOR_IN_SYNC_EN adds the frame_start resynchronisation port.
module commutator_in
   import commutator_in_pkg::*;
#(
   parameter int unsigned WL = WL_DEF,
   parameter int unsigned N  = N_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          Enable,
   input  logic [WL-1:0] in_r,
   input  logic [WL-1:0] in_i,
`ifdef COMMUTATOR_IN_SYNC_EN
   input  logic          frame_start,
`endif
   output logic [WL-1:0] out1_r,
   output logic [WL-1:0] out1_i,
   output logic [WL-1:0] out2_r,
   output logic [WL-1:0] out2_i,
   output logic [WL-1:0] out3_r,
   output logic [WL-1:0] out3_i,
   output logic [WL-1:0] out4_r,
   output logic [WL-1:0] out4_i,
   output logic          output_valid,
   output logic          frame_last
);

   localparam int unsigned CW  = clog2(N);
   localparam int unsigned Q   = N / 4;
   localparam int unsigned AW  = clog2(Q);
   localparam int unsigned AWI = (AW == 0) ? 1 : AW;
   localparam int unsigned NB  = LANES - 1;

   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      quarter;
   logic [AWI-1:0]  addr;
   logic [AWI-1:0]  waddr;
   logic [2*WL-1:0] wdata;
   logic [NB-1:0]   we;
   logic [2*WL-1:0] rdata [NB];
   logic            sync;
   logic            rd_quad;

   logic [WL-1:0]   lane_r_q [LANES];
   logic [WL-1:0]   lane_i_q [LANES];
   logic            valid_q;
   logic            last_q;

`ifdef COMMUTATOR_IN_SYNC_EN
   assign sync = Enable && frame_start;
`else
   assign sync = 1'b0;
`endif

   assign quarter = cnt_q[CW-1 -: 2];
   assign addr    = AWI'(cnt_q & CW'(Q - 1));
   assign waddr   = sync ? '0 : addr;
   assign wdata   = {in_r, in_i};
   assign rd_quad = Enable && !sync && (quarter == 2'd3);

   // Buffer write strobes and sample counter next state; a synced sample lands at buf0[0]
   always_comb begin
      we    = '0;
      cnt_d = cnt_q;
      for (int unsigned k = 0; k < NB; k++) begin
         we[k] = Enable && (sync ? (k == 0) : (32'(quarter) == k));
      end
      if (Enable) begin
         cnt_d = sync ? CW'(1) : cnt_q + CW'(1);
      end
   end

   for (genvar g = 0; g < NB; g++) begin : g_buf
      commutator_in_quarter_buffer #(
         .WL (WL),
         .AW (AWI)
      ) u_buf (
         .clk   (clk),
         .we    (we[g]),
         .waddr (waddr),
         .wdata (wdata),
         .raddr (addr),
         .rdata (rdata[g])
      );
   end

   // Counter and registered lane outputs; lane 4 bypasses the buffers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            lane_r_q[k] <= '0;
            lane_i_q[k] <= '0;
         end
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= rd_quad;
         last_q  <= rd_quad && (addr == AWI'(Q - 1));
         if (rd_quad) begin
            for (int k = 0; k < NB; k++) begin
               lane_r_q[k] <= rdata[k][2*WL-1:WL];
               lane_i_q[k] <= rdata[k][WL-1:0];
            end
            lane_r_q[LANES-1] <= in_r;
            lane_i_q[LANES-1] <= in_i;
         end
      end
   end

   assign out1_r       = lane_r_q[0];
   assign out1_i       = lane_i_q[0];
   assign out2_r       = lane_r_q[1];
   assign out2_i       = lane_i_q[1];
   assign out3_r       = lane_r_q[2];
   assign out3_i       = lane_i_q[2];
   assign out4_r       = lane_r_q[3];
   assign out4_i       = lane_i_q[3];
   assign output_valid = valid_q;
   assign frame_last   = last_q;

endmodule

// File: tb/tb_commutator_in.sv
// Directed bench for commutator_in at N=16, WL=16.
module tb_commutator_in;

   logic        clk;
   logic        rst;
   logic        Enable;
   logic [15:0] in_r, in_i;
`ifdef COMMUTATOR_IN_SYNC_EN
   logic        frame_start;
`endif
   logic [15:0] out1_r, out1_i, out2_r, out2_i, out3_r, out3_i, out4_r, out4_i;
   logic        output_valid, frame_last;
   logic [127:0] quad_obs;

   int pass_cnt  = 0;
   int total_cnt = 0;

   commutator_in #(.WL(16), .N(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .Enable       (Enable),
      .in_r         (in_r),
      .in_i         (in_i),
`ifdef COMMUTATOR_IN_SYNC_EN
      .frame_start  (frame_start),
`endif
      .out1_r       (out1_r),
      .out1_i       (out1_i),
      .out2_r       (out2_r),
      .out2_i       (out2_i),
      .out3_r       (out3_r),
      .out3_i       (out3_i),
      .out4_r       (out4_r),
      .out4_i       (out4_i),
      .output_valid (output_valid),
      .frame_last   (frame_last)
   );

   assign quad_obs = {out1_r, out1_i, out2_r, out2_i, out3_r, out3_i, out4_r, out4_i};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected quad for a ramp frame starting at value base (imag = real + 100)
   function automatic logic [127:0] exp_quad(input int base, input int m);
      logic [15:0] r1, r2, r3, r4;
      r1 = 16'(base + m);
      r2 = 16'(base + m + 4);
      r3 = 16'(base + m + 8);
      r4 = 16'(base + m + 12);
      return {r1, r1 + 16'd100, r2, r2 + 16'd100, r3, r3 + 16'd100, r4, r4 + 16'd100};
   endfunction

   // Present one input cycle, then settle just after the capturing edge
   task automatic drive(input logic en, input logic [15:0] r, input logic [15:0] i);
      Enable = en;
      in_r   = r;
      in_i   = i;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      Enable = 1'b0;
      in_r = '0;
      in_i = '0;
`ifdef COMMUTATOR_IN_SYNC_EN
      frame_start = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if (quad_obs !== 128'd0) $display("FAIL reset_data: got %h want 0", quad_obs);
      else pass_cnt++;
      total_cnt++;
      if ({output_valid, frame_last} !== 2'b00)
         $display("FAIL reset_flags: got %b want 00", {output_valid, frame_last});
      else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_ramp();
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, 16'(k), 16'(100 + k));
         total_cnt++;
         if (output_valid !== (k >= 12)) $display("FAIL ramp_valid k=%0d: got %b want %b", k, output_valid, k >= 12);
         else pass_cnt++;
         if (k >= 12) begin
            total_cnt++;
            if (quad_obs !== exp_quad(0, k - 12)) $display("FAIL ramp_quad k=%0d: got %h want %h", k, quad_obs, exp_quad(0, k - 12));
            else pass_cnt++;
            total_cnt++;
            if (frame_last !== (k == 15)) $display("FAIL ramp_last k=%0d: got %b want %b", k, frame_last, k == 15);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_toggle();
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, 16'(k), 16'(100 + k));
         total_cnt++;
         if (output_valid !== (k >= 12)) $display("FAIL tog_valid k=%0d: got %b want %b", k, output_valid, k >= 12);
         else pass_cnt++;
         if (k >= 12) begin
            total_cnt++;
            if (quad_obs !== exp_quad(0, k - 12)) $display("FAIL tog_quad k=%0d: got %h want %h", k, quad_obs, exp_quad(0, k - 12));
            else pass_cnt++;
         end
         drive(1'b0, 16'hDEAD, 16'hBEEF);
         total_cnt++;
         if ({output_valid, frame_last} !== 2'b00) $display("FAIL tog_idle_flags k=%0d: got %b want 00", k, {output_valid, frame_last});
         else pass_cnt++;
         total_cnt++;
         if (quad_obs !== exp_quad(0, (k >= 12) ? k - 12 : 3))
            $display("FAIL tog_hold k=%0d: got %h want %h", k, quad_obs, exp_quad(0, (k >= 12) ? k - 12 : 3));
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 32; k++) begin
         int base, pos;
         base = (k < 16) ? 0 : 16;
         pos  = k % 16;
         drive(1'b1, 16'(k), 16'(100 + k));
         total_cnt++;
         if (output_valid !== (pos >= 12)) $display("FAIL b2b_valid k=%0d: got %b want %b", k, output_valid, pos >= 12);
         else pass_cnt++;
         if (pos >= 12) begin
            total_cnt++;
            if (quad_obs !== exp_quad(base, pos - 12)) $display("FAIL b2b_quad k=%0d: got %h want %h", k, quad_obs, exp_quad(base, pos - 12));
            else pass_cnt++;
            total_cnt++;
            if (frame_last !== (pos == 15)) $display("FAIL b2b_last k=%0d: got %b want %b", k, frame_last, pos == 15);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int k = 0; k < 10; k++) drive(1'b1, 16'(k), 16'(100 + k));
      total_cnt++;
      if (quad_obs !== exp_quad(16, 3)) $display("FAIL mrst_pre_hold: got %h want %h", quad_obs, exp_quad(16, 3));
      else pass_cnt++;
      Enable = 1'b0;
      rst = 1'b1;
      #2;
      total_cnt++;
      if (quad_obs !== 128'd0) $display("FAIL mrst_data: got %h want 0", quad_obs);
      else pass_cnt++;
      total_cnt++;
      if (output_valid !== 1'b0) $display("FAIL mrst_valid: got %b want 0", output_valid);
      else pass_cnt++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, 16'(k), 16'(100 + k));
         total_cnt++;
         if (output_valid !== (k >= 12)) $display("FAIL mrst_valid k=%0d: got %b want %b", k, output_valid, k >= 12);
         else pass_cnt++;
         total_cnt++;
         if (quad_obs !== ((k >= 12) ? exp_quad(0, k - 12) : 128'd0))
            $display("FAIL mrst_quad k=%0d: got %h want %h", k, quad_obs, (k >= 12) ? exp_quad(0, k - 12) : 128'd0);
         else pass_cnt++;
      end
   endtask

   task automatic test_extremes();
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, 16'h8000, 16'h7FFF);
         if (k >= 12) begin
            total_cnt++;
            if (quad_obs !== {4{16'h8000, 16'h7FFF}}) $display("FAIL ext_quad k=%0d: got %h want %h", k, quad_obs, {4{16'h8000, 16'h7FFF}});
            else pass_cnt++;
            total_cnt++;
            if (output_valid !== 1'b1) $display("FAIL ext_valid k=%0d: got %b want 1", k, output_valid);
            else pass_cnt++;
         end
      end
   endtask

`ifdef COMMUTATOR_IN_SYNC_EN
   task automatic test_sync();
      for (int k = 0; k < 7; k++) begin
         drive(1'b1, 16'(k), 16'(100 + k));
         total_cnt++;
         if (output_valid !== 1'b0) $display("FAIL sync_partial_valid k=%0d: got %b want 0", k, output_valid);
         else pass_cnt++;
      end
      // frame_start without Enable must be ignored
      frame_start = 1'b1;
      drive(1'b0, 16'hDEAD, 16'hBEEF);
      for (int k = 0; k < 16; k++) begin
         frame_start = (k == 0);
         drive(1'b1, 16'(k), 16'(100 + k));
         total_cnt++;
         if (output_valid !== (k >= 12)) $display("FAIL sync_valid k=%0d: got %b want %b", k, output_valid, k >= 12);
         else pass_cnt++;
         if (k >= 12) begin
            total_cnt++;
            if (quad_obs !== exp_quad(0, k - 12)) $display("FAIL sync_quad k=%0d: got %h want %h", k, quad_obs, exp_quad(0, k - 12));
            else pass_cnt++;
            total_cnt++;
            if (frame_last !== (k == 15)) $display("FAIL sync_last k=%0d: got %b want %b", k, frame_last, k == 15);
            else pass_cnt++;
         end
      end
      frame_start = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_ramp();
      test_toggle();
      test_back_to_back();
      test_mid_reset();
      test_extremes();
`ifdef COMMUTATOR_IN_SYNC_EN
      test_sync();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
